// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// Hardwired Moore control unit for the dataPath. It fetches an instruction in
// T0-T2, waiting in T1 for memory when enabled. It then executes conditional
// branch, add-immediate, NOP or HALT in T3-T6 and keeps a saturating count of
// retired instructions.
//
// Ports
//   clk          in  : system clock, rising edge
//   reset        in  : asynchronous active-low reset
//   run          in  : permission to start / continue execution
//   ir           in  : instruction register contents (opcode in top OPC_W bits)
//   con_ff       in  : branch condition flip-flop
//   mem_ready    in  : memory read data valid
//   pc_out..ir_in out: datapath strobes
//   gra..con_in  out : register-select and operand strobes
//   control      out : ALU operation code
//   mdr_read     out : MDR mux select (01 = memory)
//   state        out : current state code
//   halted       out : high while in HALT
//   instr_count  out : saturating retired-instruction count
// -----------------------------------------------------------------------------
module control_sequencer #(
    parameter int               OPC_W       = 5,
    parameter logic [OPC_W-1:0] OPC_BR      = 5'd19,
    parameter logic [OPC_W-1:0] OPC_ADDI    = 5'd5,
    parameter logic [OPC_W-1:0] OPC_NOP     = 5'd26,
    parameter logic [OPC_W-1:0] OPC_HALT    = 5'd27,
    parameter logic [3:0]       ALU_ADD     = 4'd2,
    parameter bit               MEM_WAIT_EN = 1'b1,
    parameter int               CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [31:0]      ir,
    input  logic             con_ff,
    input  logic             mem_ready,
    output logic             pc_out,
    output logic             mar_in,
    output logic             inc_pc,
    output logic             zlow_in,
    output logic             zlow_out,
    output logic             pc_in,
    output logic             read,
    output logic             mdr_in,
    output logic             mdr_out,
    output logic             ir_in,
    output logic             gra,
    output logic             grb,
    output logic             r_in,
    output logic             r_out,
    output logic             ba_out,
    output logic             y_in,
    output logic             c_out,
    output logic             con_in,
    output logic [3:0]       control,
    output logic [1:0]       mdr_read,
    output logic [3:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    state_t           state_q, state_d;
    logic             br_q, br_d;       // path taken out of T3: 1 = branch, 0 = ADDI
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;
    logic [OPC_W-1:0] opcode;
    logic             unused_ir;

    assign opcode    = ir[31:32-OPC_W];
    assign unused_ir = ^ir[31-OPC_W:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            br_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, path memory and retire counter
    always_comb begin
        state_d = state_q;
        br_d    = br_q;
        retire  = 1'b0;
        case (state_q)
            S_IDLE: if (run) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   if (!(MEM_WAIT_EN && !mem_ready)) state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3: begin
                // Remember the path so T4/T5 do not depend on IR staying put.
                br_d = (opcode == OPC_BR);
                if (opcode == OPC_BR || opcode == OPC_ADDI) begin
                    state_d = S_T4;
                end else if (opcode == OPC_HALT) begin
                    state_d = S_HALT;
                    retire  = 1'b1;
                end else begin
                    retire  = 1'b1;   // NOP and any unlisted opcode
                end
            end
            S_T4:   state_d = S_T5;
            S_T5: begin
                if (br_q) state_d = S_T6;
                else      retire  = 1'b1;
            end
            S_T6:   retire  = 1'b1;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase

        // run only matters at retire; HALT is sticky until reset.
        if (retire && state_d != S_HALT) begin
            state_d = run ? S_T0 : S_IDLE;
        end

        cnt_d = cnt_q;
        if (retire && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Moore output decode (pc_in in T6 follows con_ff)
    always_comb begin
        pc_out   = 1'b0;
        mar_in   = 1'b0;
        inc_pc   = 1'b0;
        zlow_in  = 1'b0;
        zlow_out = 1'b0;
        pc_in    = 1'b0;
        read     = 1'b0;
        mdr_in   = 1'b0;
        mdr_out  = 1'b0;
        ir_in    = 1'b0;
        gra      = 1'b0;
        grb      = 1'b0;
        r_in     = 1'b0;
        r_out    = 1'b0;
        ba_out   = 1'b0;
        y_in     = 1'b0;
        c_out    = 1'b0;
        con_in   = 1'b0;
        control  = 4'd0;
        mdr_read = 2'b00;
        case (state_q)
            S_T0: begin
                pc_out  = 1'b1;
                mar_in  = 1'b1;
                inc_pc  = 1'b1;
                zlow_in = 1'b1;
            end
            S_T1: begin
                // Re-loading PC while waiting is harmless: Z holds PC+1.
                zlow_out = 1'b1;
                pc_in    = 1'b1;
                read     = 1'b1;
                mdr_read = 2'b01;
                mdr_in   = 1'b1;
            end
            S_T2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
            end
            S_T3: begin
                if (opcode == OPC_BR) begin
                    gra    = 1'b1;
                    r_out  = 1'b1;
                    con_in = 1'b1;
                end else if (opcode == OPC_ADDI) begin
                    grb    = 1'b1;
                    ba_out = 1'b1;
                    y_in   = 1'b1;
                end
            end
            S_T4: begin
                if (br_q) begin
                    pc_out  = 1'b1;
                    y_in    = 1'b1;
                end else begin
                    c_out   = 1'b1;
                    control = ALU_ADD;
                    zlow_in = 1'b1;
                end
            end
            S_T5: begin
                if (br_q) begin
                    c_out    = 1'b1;
                    control  = ALU_ADD;
                    zlow_in  = 1'b1;
                end else begin
                    zlow_out = 1'b1;
                    gra      = 1'b1;
                    r_in     = 1'b1;
                end
            end
            S_T6: begin
                zlow_out = 1'b1;
                pc_in    = con_ff;
            end
            default: ;
        endcase
    end

    assign state       = state_q;
    assign halted      = (state_q == S_HALT);
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

    localparam logic [4:0] BR   = 5'd19;
    localparam logic [4:0] ADDI = 5'd5;
    localparam logic [4:0] NOP  = 5'd26;
    localparam logic [4:0] HLT  = 5'd27;

    typedef struct packed {
        logic pc_out, mar_in, inc_pc, zlow_in, zlow_out, pc_in, read, mdr_in, mdr_out, ir_in;
        logic gra, grb, r_in, r_out, ba_out, y_in, c_out, con_in;
        logic [3:0] control;
        logic [1:0] mdr_read;
    } outs_t;

    typedef struct {
        logic [4:0] opc;
        logic       cf;
        int         waits;
        int         drop_at;   // step index where run drops; 99 = never
        int         cnt_after;
    } vec_t;

    logic        clk, reset, run, con_ff, mem_ready;
    logic [31:0] ir;

    // DUT (16-bit counter)
    logic pc_out, mar_in, inc_pc, zlow_in, zlow_out, pc_in, read, mdr_in, mdr_out, ir_in;
    logic gra, grb, r_in, r_out, ba_out, y_in, c_out, con_in, halted;
    logic [3:0]  control, state;
    logic [1:0]  mdr_read;
    logic [15:0] instr_count;

    // DUT with 2-bit counter for saturation
    logic s_pc_out, s_mar_in, s_inc_pc, s_zlow_in, s_zlow_out, s_pc_in, s_read, s_mdr_in, s_mdr_out, s_ir_in;
    logic s_gra, s_grb, s_r_in, s_r_out, s_ba_out, s_y_in, s_c_out, s_con_in, s_halted;
    logic [3:0] s_control, s_state;
    logic [1:0] s_mdr_read;
    logic [1:0] s_instr_count;

    outs_t act1, act2;
    assign act1 = {pc_out, mar_in, inc_pc, zlow_in, zlow_out, pc_in, read, mdr_in, mdr_out, ir_in,
                   gra, grb, r_in, r_out, ba_out, y_in, c_out, con_in, control, mdr_read};
    assign act2 = {s_pc_out, s_mar_in, s_inc_pc, s_zlow_in, s_zlow_out, s_pc_in, s_read, s_mdr_in,
                   s_mdr_out, s_ir_in, s_gra, s_grb, s_r_in, s_r_out, s_ba_out, s_y_in, s_c_out,
                   s_con_in, s_control, s_mdr_read};

    control_sequencer dut (
        .clk(clk), .reset(reset), .run(run), .ir(ir), .con_ff(con_ff), .mem_ready(mem_ready),
        .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .zlow_in(zlow_in), .zlow_out(zlow_out),
        .pc_in(pc_in), .read(read), .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in),
        .gra(gra), .grb(grb), .r_in(r_in), .r_out(r_out), .ba_out(ba_out), .y_in(y_in),
        .c_out(c_out), .con_in(con_in), .control(control), .mdr_read(mdr_read),
        .state(state), .halted(halted), .instr_count(instr_count)
    );

    control_sequencer #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .run(run), .ir(ir), .con_ff(con_ff), .mem_ready(mem_ready),
        .pc_out(s_pc_out), .mar_in(s_mar_in), .inc_pc(s_inc_pc), .zlow_in(s_zlow_in),
        .zlow_out(s_zlow_out), .pc_in(s_pc_in), .read(s_read), .mdr_in(s_mdr_in),
        .mdr_out(s_mdr_out), .ir_in(s_ir_in), .gra(s_gra), .grb(s_grb), .r_in(s_r_in),
        .r_out(s_r_out), .ba_out(s_ba_out), .y_in(s_y_in), .c_out(s_c_out), .con_in(s_con_in),
        .control(s_control), .mdr_read(s_mdr_read), .state(s_state), .halted(s_halted),
        .instr_count(s_instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_cnt;
    int exp_state;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Strobes each step asserts, straight from the instruction step tables.
    function automatic outs_t exp_out(input int st, input logic [4:0] opc, input logic cf);
        outs_t o;
        o = '0;
        case (st)
            1: begin o.pc_out = 1; o.mar_in = 1; o.inc_pc = 1; o.zlow_in = 1; end
            2: begin o.zlow_out = 1; o.pc_in = 1; o.read = 1; o.mdr_read = 2'b01; o.mdr_in = 1; end
            3: begin o.mdr_out = 1; o.ir_in = 1; end
            4: if (opc == BR) begin o.gra = 1; o.r_out = 1; o.con_in = 1; end
               else if (opc == ADDI) begin o.grb = 1; o.ba_out = 1; o.y_in = 1; end
            5: if (opc == BR) begin o.pc_out = 1; o.y_in = 1; end
               else begin o.c_out = 1; o.control = 4'd2; o.zlow_in = 1; end
            6: if (opc == BR) begin o.c_out = 1; o.control = 4'd2; o.zlow_in = 1; end
               else begin o.zlow_out = 1; o.gra = 1; o.r_in = 1; end
            7: begin o.zlow_out = 1; o.pc_in = cf; end
            default: ;
        endcase
        return o;
    endfunction

    // Runs one instruction against the reference: expected step list built
    // from the latency rules, count saturates, next state from run/HALT.
    task automatic run_instr(input logic [4:0] opc, input logic cf, input int waits, input int drop_at);
        int seq[$];
        int w;
        if (exp_state == 0) begin
            run = 1'b1;
            #1;
            chk("idle_before_start", state, 0);
            step();
        end
        ir = {opc, 27'($urandom)};
        seq.push_back(1);
        for (int k = 0; k <= waits; k++) seq.push_back(2);
        seq.push_back(3);
        seq.push_back(4);
        if (opc == BR) begin seq.push_back(5); seq.push_back(6); seq.push_back(7); end
        else if (opc == ADDI) begin seq.push_back(5); seq.push_back(6); end
        w = waits;
        foreach (seq[i]) begin
            if (i == drop_at) run = 1'b0;
            if (seq[i] == 2) begin
                mem_ready = (w > 0) ? 1'b0 : 1'b1;
                if (w > 0) w--;
            end else begin
                mem_ready = 1'($urandom);
            end
            con_ff = (seq[i] == 7) ? cf : 1'($urandom);
            #1;
            chk("state", state, seq[i]);
            chk("strobes", act1, exp_out(seq[i], opc, cf));
            chk("sat_strobes", act2, exp_out(seq[i], opc, cf));
            chk("halted_low", halted, 0);
            chk("count_hold", instr_count, exp_cnt);
            step();
        end
        exp_cnt   = (exp_cnt < 65535) ? exp_cnt + 1 : exp_cnt;
        exp_state = (opc == HLT) ? 8 : (run ? 1 : 0);
        #1;
        chk("next_state", state, exp_state);
        chk("count_retire", instr_count, exp_cnt);
        chk("halted", halted, (exp_state == 8) ? 1 : 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        run   = 1'b0;
        step();
        reset = 1'b1;
        exp_cnt   = 0;
        exp_state = 0;
    endtask

    vec_t tbl[7];
    int   sat_exp[5] = '{1, 2, 3, 3, 3};
    logic [4:0] ropc;
    int   r;
    bit   hit;

    initial begin
        tbl[0] = '{BR,   1'b1, 3, 99, 1};
        tbl[1] = '{BR,   1'b0, 0, 99, 2};
        tbl[2] = '{ADDI, 1'b0, 0, 99, 3};
        tbl[3] = '{NOP,  1'b1, 0, 99, 4};
        tbl[4] = '{5'd0, 1'b0, 1, 99, 5};
        tbl[5] = '{ADDI, 1'b1, 2, 3,  6};
        tbl[6] = '{NOP,  1'b0, 0, 99, 7};

        reset = 1'b0; run = 1'b0; ir = '0; con_ff = 1'b0; mem_ready = 1'b1;
        exp_cnt = 0; exp_state = 0;
        repeat (2) step();
        chk("rst_state", state, 0);
        chk("rst_strobes", act1, 0);
        chk("rst_halted", halted, 0);
        chk("rst_count", instr_count, 0);

        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_hold", state, 0);
            chk("idle_strobes", act1, 0);
        end

        // Directed vectors
        foreach (tbl[i]) begin
            run_instr(tbl[i].opc, tbl[i].cf, tbl[i].waits, tbl[i].drop_at);
            chk("tbl_count", instr_count, tbl[i].cnt_after);
        end

        // Randomized instruction stream
        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 3);
            if (r == 0) ropc = BR;
            else if (r == 1) ropc = ADDI;
            else if (r == 2) ropc = NOP;
            else begin
                ropc = 5'($urandom);
                while (ropc == BR || ropc == ADDI || ropc == NOP || ropc == HLT) ropc = 5'($urandom);
            end
            run_instr(ropc, 1'($urandom), $urandom_range(0, 3),
                      ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : 99);
        end

        // Asynchronous reset in the middle of T4 of a branch
        run_instr(NOP, 1'b0, 0, 0);
        run = 1'b1; ir = {BR, 27'd0}; mem_ready = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            step();
            if (state == 4'd5) hit = 1'b1;
        end
        chk("reach_t4", state, 5);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_state", state, 0);
        chk("async_rst_strobes", act1, 0);
        chk("async_rst_count", instr_count, 0);
        chk("async_rst_sat_count", s_instr_count, 0);
        step();
        reset = 1'b1; run = 1'b0;
        exp_cnt = 0; exp_state = 0;
        step();
        chk("post_rst_idle", state, 0);

        // NOP then HALT; HALT is sticky regardless of run
        run_instr(NOP, 1'b0, 0, 99);
        run_instr(HLT, 1'b0, 1, 99);
        chk("halt_count", instr_count, 2);
        for (int k = 0; k < 6; k++) begin
            run = 1'($urandom);
            step();
            chk("halt_state", state, 8);
            chk("halt_flag", halted, 1);
            chk("halt_strobes", act1, 0);
            chk("halt_count_hold", instr_count, 2);
        end

        // Saturation on the 2-bit counter
        do_reset();
        for (int k = 0; k < 5; k++) begin
            run_instr(NOP, 1'b0, 0, 99);
            chk("sat_count", s_instr_count, sat_exp[k]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
